// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Define UART_TX_IRQ_EN to build the "all queued data sent" interrupt.
`timescale 1ns/1ps
module uart_tx_io #(
   parameter int unsigned DIVISOR_RESET = 217,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        wr,
   input  logic [1:0]  addr,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        tx,
   output logic        irq
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [15:0] DIV_RST = 16'(DIVISOR_RESET);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e        state_q, state_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   per_q, per_d;
   logic          tx_q, tx_d;

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          ovr_q, ovr_d;
   logic [15:0]   div_q, div_d;
   logic [15:0]   dout_q, dout_d;

   logic          wr_data, wr_stat, wr_div, rd;
   logic          empty, full, busy;
   logic          push, pop, launch, bit_end;
   logic [15:0]   per_new;
   logic [15:0]   count16;
   logic [15:0]   rdata;
   logic          irq_en;

   assign wr_data = en & wr & (addr == 2'd0);
   assign wr_stat = en & wr & (addr == 2'd1);
   assign wr_div  = en & wr & (addr == 2'd2);
   assign rd      = en & ~wr;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign busy    = (state_q != S_IDLE);
   assign push    = wr_data & ~full;
   assign pop     = launch;

   // A divisor below 2 would collapse a bit to a single cycle.
   assign per_new = (div_q < 16'd2) ? 16'd2 : div_q;
   assign bit_end = (cnt_q == per_q - 16'd1);
   assign count16 = 16'(count_q);

   // Frame sequencer: each bit latches its own period on entry.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      tx_d    = tx_q;
      launch  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            launch = ~empty;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = 3'd0;
               cnt_d   = '0;
               per_d   = per_new;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               per_d = per_new;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (empty) begin
                  state_d = S_IDLE;
                  tx_d    = 1'b1;
               end else begin
                  launch = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // Starting a frame from IDLE or straight out of STOP looks the same.
      if (launch) begin
         state_d = S_START;
         tx_d    = 1'b0;
         shift_d = mem_q[rptr_q];
         cnt_d   = '0;
         per_d   = per_new;
      end
   end

   // FIFO pointers, occupancy and the sticky overrun flag.
   always_comb begin
      wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q + CW'(push) - CW'(pop);
      ovr_d   = ovr_q;
      if (wr_stat && din[3]) begin
         ovr_d = 1'b0;
      end
      if (wr_data && full) begin
         ovr_d = 1'b1;
      end
      div_d = wr_div ? din : div_q;
   end

   // Register read mux; dout is zero whenever no read is in flight.
   always_comb begin
      rdata = '0;
      case (addr)
         2'd1: rdata = {count16[7:0], 3'b000, irq_en,
                        ovr_q, busy, full, empty};
         2'd2: rdata = div_q;
         default: rdata = '0;
      endcase
      dout_d = rd ? rdata : 16'h0000;
   end

   // FIFO storage needs no reset; occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= din[7:0];
      end
   end

   // Main state register; reset aborts any frame and idles the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         bit_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         per_q   <= 16'd2;
         tx_q    <= 1'b1;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovr_q   <= 1'b0;
         div_q   <= DIV_RST;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         tx_q    <= tx_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovr_q   <= ovr_d;
         div_q   <= div_d;
         dout_q  <= dout_d;
      end
   end

`ifdef UART_TX_IRQ_EN
   logic irq_en_q;
   logic irq_q;

   assign irq_en = irq_en_q;

   // Interrupt enable and a registered "everything sent" request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_stat) begin
            irq_en_q <= din[4];
         end
         irq_q <= irq_en_q & empty & ~busy;
      end
   end

   assign irq = irq_q;
`else
   assign irq_en = 1'b0;
   assign irq    = 1'b0;
`endif

   assign tx   = tx_q;
   assign dout = dout_q;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed bench for uart_tx_io.
// Register table plus hand sequences for framing, overflow and reset.
`timescale 1ns/1ps
module tb_uart_tx_io;

   logic        clk;
   logic        reset;
   logic        en;
   logic        wr;
   logic [1:0]  addr;
   logic [15:0] din;
   logic [15:0] dout;
   logic        tx;
   logic        irq;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef UART_TX_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   typedef struct {
      logic        wr;
      logic [1:0]  addr;
      logic [15:0] din;
      logic [15:0] exp;
   } vec_t;

   vec_t vec [13];

   uart_tx_io dut (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .wr    (wr),
      .addr  (addr),
      .din   (din),
      .dout  (dout),
      .tx    (tx),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [15:0] act,
                        input logic [15:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
      en = 1'b1; wr = 1'b1; addr = a; din = d;
      tick();
      en = 1'b0; wr = 1'b0; addr = 2'd0; din = 16'h0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [15:0] v);
      en = 1'b1; wr = 1'b0; addr = a;
      tick();
      en = 1'b0; addr = 2'd0;
      v = dout;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   // Expected line level k cycles after the first start bit.
   function automatic logic wave(input logic [7:0] b0, input logic [7:0] b1,
                                 input int per, input int k);
      int fl;
      int f;
      int pos;
      logic [7:0] b;
      fl  = 10 * per;
      f   = k / fl;
      pos = (k % fl) / per;
      b   = (f == 0) ? b0 : b1;
      if (f > 1) return 1'b1;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return b[pos-1];
   endfunction

   // Receiver for period-4 frames: samples each bit mid-period.
   task automatic rx_byte(output logic [7:0] b, output logic ok);
      int n;
      ok = 1'b0;
      b  = 8'h00;
      n  = 0;
      while (tx !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      if (tx !== 1'b0) return;
      repeat (2) tick();
      if (tx !== 1'b0) return;
      for (int i = 0; i < 8; i++) begin
         repeat (4) tick();
         b[i] = tx;
      end
      repeat (4) tick();
      ok = (tx === 1'b1);
   endtask

   initial begin
      logic [15:0] v;
      logic [7:0]  b;
      logic        ok;
      logic        found;
      int          errs;

      vec[0]  = '{1'b0, 2'd1, 16'h0000, 16'h0001};
      vec[1]  = '{1'b0, 2'd0, 16'h0000, 16'h0000};
      vec[2]  = '{1'b0, 2'd3, 16'h0000, 16'h0000};
      vec[3]  = '{1'b1, 2'd2, 16'h1234, 16'h0000};
      vec[4]  = '{1'b0, 2'd2, 16'h0000, 16'h1234};
      vec[5]  = '{1'b1, 2'd2, 16'h0000, 16'h0000};
      vec[6]  = '{1'b0, 2'd2, 16'h0000, 16'h0000};
      vec[7]  = '{1'b1, 2'd1, 16'h0010, 16'h0000};
      vec[8]  = '{1'b0, 2'd1, 16'h0000, {11'b0, IRQ_ON, 4'b0001}};
      vec[9]  = '{1'b1, 2'd1, 16'h0008, 16'h0000};
      vec[10] = '{1'b0, 2'd1, 16'h0000, 16'h0001};
      vec[11] = '{1'b1, 2'd2, 16'hFFFF, 16'h0000};
      vec[12] = '{1'b0, 2'd2, 16'h0000, 16'hFFFF};

      reset = 1'b1; en = 1'b0; wr = 1'b0; addr = 2'd0; din = 16'h0;
      repeat (3) tick();
      check("rst_tx", {15'b0, tx}, 16'h0001);
      check("rst_dout", dout, 16'h0000);
      check("rst_irq", {15'b0, irq}, 16'h0000);
      reset = 1'b0;
      tick();

      // Read latency and default register values.
      bus_read(2'd1, v);
      check("stat_after_rst", v, 16'h0001);
      tick();
      check("dout_returns_0", dout, 16'h0000);
      bus_read(2'd2, v);
      check("div_after_rst", v, 16'h00D9);

      for (int i = 0; i < 13; i++) begin
         if (vec[i].wr) begin
            bus_write(vec[i].addr, vec[i].din);
         end else begin
            bus_read(vec[i].addr, v);
            check($sformatf("vec%0d", i), v, vec[i].exp);
         end
      end

      // Single 0x55 frame at four cycles per bit.
      do_reset();
      bus_write(2'd2, 16'd4);
      bus_write(2'd0, 16'h0055);
      check("tx_high_at_E", {15'b0, tx}, 16'h0001);
      errs = 0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (tx !== wave(8'h55, 8'hFF, 4, k)) errs++;
      end
      check("frame55_bits", 16'(errs), 16'h0000);
      bus_read(2'd1, v);
      check("busy_last_stop", v, 16'h0005);
      bus_read(2'd1, v);
      check("busy_cleared", v, 16'h0001);
      check("tx_idle_after", {15'b0, tx}, 16'h0001);

      // Overflow: a primer byte occupies the shifter, then 17 writes.
      do_reset();
      bus_write(2'd2, 16'd1000);
      en = 1'b1; wr = 1'b1; addr = 2'd0; din = 16'h00FF;
      tick();
      for (int i = 0; i < 17; i++) begin
         din = 16'h0010 + 16'(i);
         tick();
      end
      en = 1'b0; wr = 1'b0; din = 16'h0;
      bus_read(2'd1, v);
      check("ovr_full_cnt16", v, 16'h100E);
      bus_write(2'd1, 16'h0008);
      bus_read(2'd1, v);
      check("ovr_cleared", v, 16'h1006);
      bus_write(2'd2, 16'd4);
      found = 1'b0;
      for (int n = 0; n < 3000 && !found; n++) begin
         tick();
         if (tx === 1'b1) found = 1'b1;
      end
      check("primer_start_ends", {15'b0, found}, 16'h0001);
      for (int j = 0; j < 16; j++) begin
         rx_byte(b, ok);
         check($sformatf("rx_byte%0d", j), {7'b0, ok, b},
               {7'b0, 1'b1, 8'h10 + 8'(j)});
      end
      errs = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         if (tx !== 1'b1) errs++;
      end
      check("no_17th_byte", 16'(errs), 16'h0000);
      bus_read(2'd1, v);
      check("drained", v, 16'h0001);

      // Back-to-back frames 0xA5, 0x3C at two cycles per bit.
      do_reset();
      bus_write(2'd2, 16'd2);
      bus_write(2'd0, 16'h00A5);
      en = 1'b1; wr = 1'b1; addr = 2'd0; din = 16'h003C;
      tick();
      en = 1'b0; wr = 1'b0; din = 16'h0;
      errs = 0;
      if (tx !== wave(8'hA5, 8'h3C, 2, 0)) errs++;
      for (int k = 1; k < 40; k++) begin
         tick();
         if (tx !== wave(8'hA5, 8'h3C, 2, k)) errs++;
      end
      check("b2b_wave", 16'(errs), 16'h0000);
      bus_read(2'd1, v);
      check("b2b_last_stop", v, 16'h0005);
      check("b2b_tx_idle", {15'b0, tx}, 16'h0001);
      bus_read(2'd1, v);
      check("b2b_done", v, 16'h0001);

      // Reset in the middle of data bit 3 with one byte still queued.
      do_reset();
      bus_write(2'd2, 16'd4);
      bus_write(2'd0, 16'h0000);
      bus_write(2'd0, 16'h0000);
      repeat (17) tick();
      check("pre_reset_low", {15'b0, tx}, 16'h0000);
      reset = 1'b1;
      #1;
      check("rst_async_tx", {15'b0, tx}, 16'h0001);
      check("rst_async_dout", dout, 16'h0000);
      tick();
      reset = 1'b0;
      errs = 0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (tx !== 1'b1) errs++;
      end
      check("no_resume", 16'(errs), 16'h0000);
      bus_read(2'd1, v);
      check("rst_fifo_empty", v, 16'h0001);
      bus_read(2'd2, v);
      check("rst_div_back", v, 16'h00D9);

      // Interrupt tracks "queue empty and line idle".
      do_reset();
      check("irq_rst", {15'b0, irq}, 16'h0000);
      bus_write(2'd2, 16'd2);
      bus_write(2'd1, 16'h0010);
      tick();
      check("irq_idle_en", {15'b0, irq}, {15'b0, IRQ_ON});
      bus_write(2'd0, 16'h0000);
      errs = 0;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (irq !== 1'b0) errs++;
      end
      check("irq_low_busy", 16'(errs), 16'h0000);
      tick();
      check("irq_after_idle", {15'b0, irq}, {15'b0, IRQ_ON});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_io.md
UART_TX_IO -- requirements
Module: uart_tx_io

Interface
REQ-001 SHALL have parameter DIVISOR_RESET, default 217, reset bit period in clk cycles (115200 baud at 25 MHz).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO depth in bytes, a power of 2 from 2 to 256.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  CPU access strobe, block already selected by io decode.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read; valid with en.
REQ-007 SHALL have port addr  input  2  register select: 0 DATA, 1 STATUS/CTRL, 2 DIVISOR, 3 reserved.
REQ-008 SHALL have port din  input  16  CPU write data.
REQ-009 SHALL have port dout  output  16  registered read data.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port irq  output  1  level interrupt request to the irq controller.

Function
REQ-012 SHALL, on en&wr&addr==0, push din[7:0] into the FIFO at that edge; if the FIFO is full the byte is dropped and sticky OVR is set, even when a pop occurs the same cycle.
REQ-013 SHALL, on en&~wr, load dout at that edge with the addressed register, and otherwise load dout with 0 at every edge, so the CPU samples read data one cycle after the access and dout can be OR-muxed.
REQ-014 SHALL read STATUS as: bit0 EMPTY, bit1 FULL, bit2 BUSY (FSM not IDLE), bit3 OVR, bit4 IRQ_EN, bits[15:8] FIFO count; other bits 0. DATA and reserved addresses read 0.
REQ-015 SHALL, on a STATUS write, set IRQ_EN from din[4] and clear OVR when din[3]=1.
REQ-016 SHALL hold DIVISOR as a 16-bit register, read back as written; bit period = max(DIVISOR,2) cycles.
REQ-017 SHALL run an FSM with states IDLE, START, DATA, STOP; frame is 8N1, LSB first.
REQ-018 SHALL, in IDLE with FIFO non-empty, pop one byte at the next edge and enter START with tx low from that edge.
REQ-019 SHALL, for a byte written into an empty FIFO at edge E while idle, drive tx low from edge E+1.
REQ-020 SHALL hold each of START, the 8 DATA bits and STOP for exactly one bit period; after STOP the FSM returns to IDLE, or enters START directly if the FIFO is non-empty, with no idle gap.
REQ-021 SHALL latch the bit period at the start of each bit; a DIVISOR write mid-frame takes effect at the next bit boundary.
REQ-022 SHALL wrap FIFO pointers modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH; simultaneous push and pop on a non-full, non-empty FIFO leaves count unchanged.
REQ-023 SHALL drive tx from a register, glitch-free.

Reset
REQ-024 SHALL, while reset is high, force FSM IDLE, tx=1, dout=0, irq=0, FIFO empty, OVR=0, IRQ_EN=0, DIVISOR=DIVISOR_RESET.
REQ-025 SHALL, on reset mid-frame, abort the frame and drive tx high immediately; no partial byte resumes after release.

Configuration
REQ-026 SHALL, with macro UART_TX_IRQ_EN defined, drive irq registered high when IRQ_EN=1, the FIFO is empty and the FSM is IDLE, i.e. all queued data fully sent.
REQ-027 SHALL, without UART_TX_IRQ_EN, tie irq to 0, ignore din[4] on STATUS writes, and read STATUS bit4 as 0.

Verification
REQ-028 SHALL cover: after reset, read STATUS -> dout=0x0001 on the following cycle, 0 on the cycle after; read DIVISOR -> 0x00D9.
REQ-029 SHALL cover: DIVISOR=4, write DATA 0x55 -> tx low at E+1, then bits 1,0,1,0,1,0,1,0 and stop 1, each 4 cycles; BUSY clears 40 cycles after E+1.
REQ-030 SHALL cover: DIVISOR=1000, 17 back-to-back DATA writes -> count=16, FULL=1, OVR=1; the 17th byte is never transmitted; writing STATUS 0x0008 clears OVR.
REQ-031 SHALL cover: two queued bytes 0xA5, 0x3C at DIVISOR=2 -> second start bit immediately follows the first stop bit; total 40 cycles.
REQ-032 SHALL cover: reset asserted during DATA bit 3 -> tx=1 and count=0 immediately; after release tx stays high with no transmission.
REQ-033 SHALL cover: with UART_TX_IRQ_EN, IRQ_EN=1, send 0x00 -> irq low while BUSY, high the cycle after return to IDLE; without the macro irq stays 0.
